// File: rtl/seven_seg_scanner.sv
// Time-multiplexed anode scanner for common-anode 7-segment displays with blanking,
// scan enable, frame strobe and optional PWM dimming (enabled by defining SEG_DIM_EN).
module seven_seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_BITS  = 18,
  parameter int SEL_W      = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [NUM_DIGITS-1:0] DigitMask,
`ifdef SEG_DIM_EN
  input  logic [3:0]            Brightness,
`endif
  output logic [NUM_DIGITS-1:0] AN,
  output logic [SEL_W-1:0]      Sel,
  output logic                  FrameTick
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_DIGITS - 1);

  logic [SCAN_BITS-1:0]  cnt;
  logic [SCAN_BITS-1:0]  cnt_next;
  logic [SEL_W-1:0]      idx;
  logic [SEL_W-1:0]      idx_next;
  logic                  wrap;
  logic                  gate;
  logic [NUM_DIGITS-1:0] an_next;

  // Dimming gate looks at the count the digit will have after this edge,
  // so AN and the PWM phase stay aligned.
`ifdef SEG_DIM_EN
  assign gate = (cnt_next[SCAN_BITS-1 -: 4] <= Brightness);
`else
  assign gate = 1'b1;
`endif

  always_comb begin
    cnt_next = cnt + SCAN_BITS'(1);
    wrap     = &cnt;
    idx_next = idx;
    if (wrap) begin
      idx_next = (idx == LAST) ? '0 : idx + SEL_W'(1);
    end
    an_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((SEL_W'(i) == idx_next) && !DigitMask[i] && gate) begin
        an_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= '0;
      idx       <= '0;
      AN        <= '1;
      FrameTick <= 1'b0;
    end else if (Enable) begin
      cnt       <= cnt_next;
      idx       <= idx_next;
      AN        <= an_next;
      FrameTick <= wrap && (idx == LAST);
    end else begin
      AN        <= '1;
      FrameTick <= 1'b0;
    end
  end

  assign Sel = idx;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a 4-digit and a 3-digit instance (SCAN_BITS=4) share
// Reset/Enable; a reference model feeds a scoreboard while a vector table checks milestones.
module tb_seven_seg_scanner;

  logic       Clk = 1'b0;
  logic       Reset, Enable;
  logic [3:0] mask4;
  logic [3:0] bright;
  logic [3:0] AN4;
  logic [1:0] Sel4;
  logic       Ft4;
  logic [2:0] AN3;
  logic [1:0] Sel3;
  logic       Ft3;

  always #5 Clk = ~Clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .SCAN_BITS(4)) d4 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .DigitMask(mask4),
`ifdef SEG_DIM_EN
    .Brightness(bright),
`endif
    .AN(AN4), .Sel(Sel4), .FrameTick(Ft4)
  );

  seven_seg_scanner #(.NUM_DIGITS(3), .SCAN_BITS(4)) d3 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .DigitMask(mask4[2:0]),
`ifdef SEG_DIM_EN
    .Brightness(bright),
`endif
    .AN(AN3), .Sel(Sel3), .FrameTick(Ft3)
  );

  typedef struct {
    logic [3:0] cnt;
    int         idx;
    logic [3:0] an;
    logic       ft;
  } mstate_t;

  typedef struct {
    logic [3:0] an4; int sel4; logic ft4;
    logic [2:0] an3; int sel3; logic ft3;
  } exp_t;

  typedef struct {
    bit rst; bit en; logic [3:0] mask; int cycles;
    logic [3:0] an4; int sel4; logic [2:0] an3; int sel3;
  } vec_t;

  mstate_t m4, m3;
  exp_t    sbq[$];
  vec_t    vec[13];
  int      errors = 0;
  int      checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mstate_t mnext(input mstate_t s, input int n, input bit rst,
                                    input bit en, input logic [3:0] mask,
                                    input logic [3:0] br);
    mstate_t r = s;
    bit g;
    if (rst) begin
      r.cnt = 0; r.idx = 0; r.an = 4'hF; r.ft = 0;
    end else if (!en) begin
      r.an = 4'hF; r.ft = 0;
    end else begin
      r.ft  = (s.cnt == 4'hF) && (s.idx == n - 1);
      r.cnt = s.cnt + 4'd1;
      if (s.cnt == 4'hF) r.idx = (s.idx == n - 1) ? 0 : s.idx + 1;
`ifdef SEG_DIM_EN
      g = (r.cnt <= br);
`else
      g = 1'b1;
`endif
      r.an = 4'hF;
      if (!mask[r.idx] && g) r.an[r.idx] = 1'b0;
    end
    return r;
  endfunction

  task automatic step(input bit rst, input bit en);
    exp_t e;
    m4 = mnext(m4, 4, rst, en, mask4, bright);
    m3 = mnext(m3, 3, rst, en, {1'b0, mask4[2:0]}, bright);
    e.an4 = m4.an; e.sel4 = m4.idx; e.ft4 = m4.ft;
    e.an3 = m3.an[2:0]; e.sel3 = m3.idx; e.ft3 = m3.ft;
    sbq.push_back(e);
    Reset  = rst;
    Enable = en;
    @(posedge Clk);
    #1;
    e = sbq.pop_front();
    check("sb_an4", AN4, e.an4);
    check("sb_sel4", Sel4, e.sel4);
    check("sb_ft4", Ft4, e.ft4);
    check("sb_an3", AN3, e.an3);
    check("sb_sel3", Sel3, e.sel3);
    check("sb_ft3", Ft3, e.ft3);
  endtask

  initial begin
    int n3, n4, first3, lit;
    Reset = 1'b1; Enable = 1'b1; mask4 = 4'h0; bright = 4'hF;
    m4 = '{cnt: 0, idx: 0, an: 4'hF, ft: 0};
    m3 = m4;

    //          rst en mask  cyc  an4     sel4 an3     sel3
    vec[0]  = '{1, 1, 4'h0,  2, 4'b1111, 0, 3'b111, 0};
    vec[1]  = '{0, 1, 4'h0,  1, 4'b1110, 0, 3'b110, 0};
    vec[2]  = '{0, 1, 4'h0, 15, 4'b1101, 1, 3'b101, 1};
    vec[3]  = '{0, 1, 4'h0,  3, 4'b1101, 1, 3'b101, 1};
    vec[4]  = '{0, 0, 4'h0,  5, 4'b1111, 1, 3'b111, 1};
    vec[5]  = '{0, 1, 4'h0, 12, 4'b1101, 1, 3'b101, 1};
    vec[6]  = '{0, 1, 4'h0,  1, 4'b1011, 2, 3'b011, 2};
    vec[7]  = '{0, 1, 4'h4,  1, 4'b1111, 2, 3'b111, 2};
    vec[8]  = '{0, 1, 4'h4, 15, 4'b0111, 3, 3'b110, 0};
    vec[9]  = '{0, 1, 4'h0, 16, 4'b1110, 0, 3'b101, 1};
    vec[10] = '{0, 1, 4'h0, 35, 4'b1011, 2, 3'b110, 0};
    vec[11] = '{1, 1, 4'h0,  1, 4'b1111, 0, 3'b111, 0};
    vec[12] = '{0, 1, 4'h0,  1, 4'b1110, 0, 3'b110, 0};

    for (int v = 0; v < 13; v++) begin
      mask4 = vec[v].mask;
      repeat (vec[v].cycles) step(vec[v].rst, vec[v].en);
      check($sformatf("tbl%0d_an4", v), AN4, vec[v].an4);
      check($sformatf("tbl%0d_sel4", v), Sel4, vec[v].sel4);
      check($sformatf("tbl%0d_an3", v), AN3, vec[v].an3);
      check($sformatf("tbl%0d_sel3", v), Sel3, vec[v].sel3);
    end

    // Frame strobe spacing and width over two 3-digit frames
    mask4 = 4'h0;
    step(1, 1);
    n3 = 0; n4 = 0; first3 = 0;
    for (int k = 1; k <= 96; k++) begin
      step(0, 1);
      if (Ft3 === 1'b1) begin
        n3++;
        if (first3 == 0) first3 = k;
        check("ft3_sel_wrap", Sel3, 0);
      end
      if (Ft4 === 1'b1) n4++;
    end
    check("ft3_count", n3, 2);
    check("ft3_first_edge", first3, 48);
    check("ft4_count", n4, 1);

`ifdef SEG_DIM_EN
    step(1, 1);
    bright = 4'd3; lit = 0;
    for (int k = 0; k < 16; k++) begin step(0, 1); if (AN4 != 4'hF) lit++; end
    check("dim3_lit", lit, 4);
    bright = 4'd0; lit = 0;
    for (int k = 0; k < 16; k++) begin step(0, 1); if (AN4 != 4'hF) lit++; end
    check("dim0_lit", lit, 1);
    bright = 4'd15; lit = 0;
    for (int k = 0; k < 16; k++) begin step(0, 1); if (AN4 != 4'hF) lit++; end
    check("dim15_lit", lit, 16);
`endif

    check("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised time-multiplexed scan controller for common-anode 7-segment displays on Basys3-class boards. It cycles through `NUM_DIGITS` anodes at a rate set by a prescaler and outputs the active digit index so downstream segment muxes can pick that digit's data. It adds per-digit blanking, a scan enable, a frame-complete strobe and optional PWM dimming. It is the successor of the fixed two-digit controller and drops in at the same point: between the board clock/reset and the segment-data mux.

## Interface
- `NUM_DIGITS`, default 4: number of scanned digits, legal range 1..8.
- `SCAN_BITS`, default 18: prescaler width. Each digit is lit for 2^SCAN_BITS enabled cycles. Minimum 4.
- `SEL_W`, default `NUM_DIGITS>1 ? $clog2(NUM_DIGITS) : 1`: digit index width. Derived; do not override.
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high.
- `Enable`  in  1  scan advance enable. Low = freeze the scan and blank the display.
- `DigitMask`  in  NUM_DIGITS  1 = digit i blanked (its anode held high).
- `Brightness`  in  4  dimming level, 15 = full. Present only with `SEG_DIM_EN`.
- `AN`  out  NUM_DIGITS  anodes, active-low, registered.
- `Sel`  out  SEL_W  index of the current digit, registered.
- `FrameTick`  out  1  one-cycle pulse when a full frame completes.

## Operation
- Registers:
  - prescaler `cnt[SCAN_BITS-1:0]`
  - digit index `idx` (drives `Sel`)
  - `AN`
  - `FrameTick`
- Reset values: `cnt`=0, `idx`=0, `AN`=all ones, `FrameTick`=0. These also apply when `Reset` is asserted mid-scan; reset has priority over every other input.
- `Enable`=1, each cycle:
  - `cnt` increments modulo 2^SCAN_BITS.
  - When `cnt` is all ones: `idx` advances on the same edge. It wraps from NUM_DIGITS-1 to 0, including non-power-of-2 counts. `idx` never takes a value ≥ NUM_DIGITS.
- `Enable`=0: `cnt` and `idx` hold; `AN` is all ones on the next edge; `FrameTick`=0.
- `AN` next value, when enabled: bit i = 0 only if i == next `idx`, `DigitMask[i]`=0, and the dimming gate is open. Otherwise bit i = 1. At most one `AN` bit is low at any time.
- `FrameTick` next value = 1 only when enabled, `cnt` is all ones, and `idx` == NUM_DIGITS-1.
- `NUM_DIGITS`=1: `idx` stays 0. `FrameTick` pulses every 2^SCAN_BITS enabled cycles.

## Timing
- `AN`, `Sel` and `FrameTick` change only on rising `Clk` edges.
- `Sel` and `AN` switch on the same edge. There is no cycle where `AN` points at one digit while `Sel` points at another.
- First enabled cycle after reset releases: `AN` = ~(1<<0) (e.g. 4'b1110) one edge later.
- Digit period: 2^SCAN_BITS enabled cycles. Frame period: NUM_DIGITS·2^SCAN_BITS enabled cycles.
- A `DigitMask` or `Brightness` change takes effect on `AN` at the next edge. The scan position is unaffected.
- `Enable` toggling never skips a digit and never corrupts `cnt`.

## Configuration
- Macro: `SEG_DIM_EN`.
- Defined:
  - The `Brightness` port exists.
  - Dimming gate is open when `cnt[SCAN_BITS-1 -: 4]` ≤ `Brightness`.
  - Brightness=15 gives full on-time; 0 gives 1/16 duty per digit slot. The gate is computed from next `cnt`.
- Undefined:
  - No `Brightness` port.
  - The gate is always open and the dimming logic is absent from the netlist.

## Test plan
- Reset/start (NUM_DIGITS=4, SCAN_BITS=4, Enable=1, mask 0): `AN`=4'b1111 and `Sel`=0 during reset. One edge after reset falls, `AN`=4'b1110. After 16 cycles, `AN`=4'b1101 and `Sel`=1.
- Non-power-of-2 wrap (NUM_DIGITS=3, SCAN_BITS=4): `Sel` sequence is 0,1,2,0 with 16 cycles each. `FrameTick` pulses for exactly 1 cycle, coincident with `Sel` going 2→0, every 48 cycles.
- Masking: `DigitMask`=4'b0100 → `AN` stays 4'b1111 for the whole digit-2 slot while `Sel`=2. Other digits light normally.
- Enable freeze: drop `Enable` for 5 cycles mid-digit-1 → `AN`=4'b1111 and `Sel` holds 1. On resume, digit 1 completes its remaining count before advancing.
- Reset mid-scan at `Sel`=2 → next edge gives `AN`=all ones, `Sel`=0, `cnt`=0, `FrameTick`=0.
- With `SEG_DIM_EN` (SCAN_BITS=4), Brightness=3 → `AN` low for 4 of 16 cycles per slot. Brightness=15 → low all 16. Brightness=0 → low 1 of 16.
